// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU control codes and FSM state type for the execute stage.
// The control decoder imports the same package so both ends agree on the encoding.
package alu_exec_unit_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_BEQ  = 4'd8;
  localparam logic [3:0] ALU_BNEQ = 4'd9;
  localparam logic [3:0] ALU_BGE  = 4'd10;
  localparam logic [3:0] ALU_BGT  = 4'd11;
  localparam logic [3:0] ALU_BLE  = 4'd12;
  localparam logic [3:0] ALU_BLT  = 4'd13;
  localparam logic [3:0] ALU_SLT  = 4'd14;
  localparam logic [3:0] ALU_SLTU = 4'd15;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle logical shifter: load captures value, count and direction;
// each step moves one bit. acc_next is the value the accumulator takes on the next step.
module alu_serial_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               dir_right,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   acc_next,
  output logic               last
);

  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] cnt;
  logic               dir_q;

  assign acc_next = dir_q ? (acc >> 1) : (acc << 1);
  // The step that takes cnt from 1 to 0 produces the final value.
  assign last     = (cnt == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
    end else if (load) begin
      acc   <= din;
      cnt   <= shamt;
      dir_q <= dir_right;
    end else if (step) begin
      acc   <= acc_next;
      cnt   <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ALU and branch compare, plus a serial shifter for
// non-zero SLL/SRL. Handshake: an op is accepted when start & ~busy; done pulses one cycle with results.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               branch_taken,
  output state_e             dbg_state
);

  state_e           state, state_n;
  logic             accept, is_shift;
  logic             sh_load, sh_step, sh_last;
  logic             cap_single, cap_shift;
  logic [WIDTH-1:0] sh_next, diff, alu_res;
  logic             lt_s, lt_u, eq, br;

  assign busy      = (state == ST_SHIFT);
  assign dbg_state = state;
  assign accept    = start & ~busy;
  assign is_shift  = (alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SRL);
  assign diff      = op_a - op_b;
  assign lt_s      = $signed(op_a) < $signed(op_b);
  assign lt_u      = op_a < op_b;
  assign eq        = (op_a == op_b);

  always_comb begin
    alu_res = '0;
    br      = 1'b0;
    case (alu_ctrl)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = diff;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_NOR:  alu_res = ~(op_a | op_b);
      // Only reached here with shamt==0; non-zero amounts go through the serial shifter.
      ALU_SLL, ALU_SRL: alu_res = op_b;
      ALU_BEQ:  begin alu_res = diff; br = eq;           end
      ALU_BNEQ: begin alu_res = diff; br = ~eq;          end
      ALU_BGE:  begin alu_res = diff; br = ~lt_s;        end
      ALU_BGT:  begin alu_res = diff; br = ~lt_s & ~eq;  end
      ALU_BLE:  begin alu_res = diff; br = lt_s | eq;    end
      ALU_BLT:  begin alu_res = diff; br = lt_s;         end
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt_s};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, lt_u};
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_n    = state;
    sh_load    = 1'b0;
    sh_step    = 1'b0;
    cap_single = 1'b0;
    cap_shift  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            sh_load = 1'b1;
            state_n = ST_SHIFT;
          end else begin
            cap_single = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        sh_step = 1'b1;
        if (sh_last) begin
          cap_shift = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      done         <= 1'b0;
      result       <= '0;
      zero         <= 1'b1;
      branch_taken <= 1'b0;
    end else begin
      state <= state_n;
      done  <= cap_single | cap_shift;
      if (cap_single) begin
        result       <= alu_res;
        zero         <= (alu_res == '0);
        branch_taken <= br;
      end else if (cap_shift) begin
        result       <= sh_next;
        zero         <= (sh_next == '0);
        branch_taken <= 1'b0;
      end
    end
  end

  alu_serial_shifter #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .step     (sh_step),
    .dir_right(alu_ctrl == ALU_SRL),
    .din      (op_b),
    .shamt    (shamt),
    .acc_next (sh_next),
    .last     (sh_last)
  );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed and random ops checked against
// an arithmetic reference model, plus busy-ignore, back-to-back and mid-shift reset cases.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] op_a, op_b;
  logic [4:0]   shamt;
  logic         busy, done, zero, branch_taken;
  logic [W-1:0] result;
  state_e       dbg_state;

  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .shamt(shamt), .busy(busy), .done(done),
    .result(result), .zero(zero), .branch_taken(branch_taken),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: results straight from the arithmetic definition of each code.
  task automatic model(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh, output logic [W-1:0] res, output logic br);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    br = 1'b0;
    case (code)
      4'd0: res = W'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      4'd1: res = W'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = ~(a | b);
      4'd6: res = b << sh;
      4'd7: res = b >> sh;
      4'd14: res = (sa < sb) ? 1 : 0;
      4'd15: res = (64'(a) < 64'(b)) ? 1 : 0;
      default: begin
        res = W'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
        case (code)
          4'd8:  br = (sa == sb);
          4'd9:  br = (sa != sb);
          4'd10: br = (sa >= sb);
          4'd11: br = (sa > sb);
          4'd12: br = (sa <= sb);
          default: br = (sa < sb);
        endcase
      end
    endcase
  endtask

  // Called just after a rising edge; returns in the done cycle so the next call is back-to-back.
  task automatic run_op(input string tag, input logic [3:0] code, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] sh, input bit poke);
    logic [W-1:0] er;
    logic eb;
    int n, bc, exl;
    model(code, a, b, sh, er, eb);
    exp_q.push_back(er);
    exl = ((code == 4'd6 || code == 4'd7) && sh != 0) ? sh + 1 : 1;
    alu_ctrl = code; op_a = a; op_b = b; shamt = sh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; shamt = 5'($urandom_range(0, 31));
    n = 1; bc = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) begin
        bc++;
        if (poke) begin
          start = 1'b1;
          alu_ctrl = 4'($urandom_range(0, 15));
          op_a = $urandom; op_b = $urandom;
          shamt = 5'($urandom_range(1, 31));
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    check({tag, "_done"}, W'(done), 1);
    check({tag, "_latency"}, W'(n), W'(exl));
    check({tag, "_busy_cycles"}, W'(bc), W'(exl - 1));
    check({tag, "_result"}, result, exp_q.pop_front());
    check({tag, "_zero"}, W'(zero), W'(er == 0));
    check({tag, "_branch"}, W'(branch_taken), W'(eb));
  endtask

  initial begin
    int dones;
    logic [3:0] c;
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; alu_ctrl = '0; op_a = '0; op_b = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), 0);
    check("rst_done", W'(done), 0);
    check("rst_result", result, 0);
    check("rst_zero", W'(zero), 1);
    check("rst_branch", W'(branch_taken), 0);
    check("rst_state", W'(dbg_state), W'(ST_IDLE));
    rst = 1'b0;

    run_op("add_7_5", 4'd0, 32'd7, 32'd5, 5'd0, 1'b0);
    run_op("sub_5_5", 4'd1, 32'd5, 32'd5, 5'd3, 1'b0);
    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    run_op("nor_0_0", 4'd5, 32'd0, 32'd0, 5'd0, 1'b0);
    run_op("slt_m1_1", 4'd14, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    run_op("sltu_max_1", 4'd15, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    run_op("sll_31", 4'd6, 32'd0, 32'd1, 5'd31, 1'b0);
    run_op("srl_4", 4'd7, 32'd0, 32'h8000_0000, 5'd4, 1'b0);
    run_op("srl_0", 4'd7, 32'd0, 32'h8000_0000, 5'd0, 1'b0);
    run_op("blt_m2_3", 4'd13, -32'sd2, 32'd3, 5'd0, 1'b0);
    run_op("bge_m2_3", 4'd10, -32'sd2, 32'd3, 5'd0, 1'b0);
    run_op("ble_m2_3", 4'd12, -32'sd2, 32'd3, 5'd0, 1'b0);
    run_op("bgt_m2_3", 4'd11, -32'sd2, 32'd3, 5'd0, 1'b0);
    run_op("bneq_m2_3", 4'd9, -32'sd2, 32'd3, 5'd0, 1'b0);
    run_op("beq_9_9", 4'd8, 32'd9, 32'd9, 5'd0, 1'b0);
    run_op("bge_9_9", 4'd10, 32'd9, 32'd9, 5'd0, 1'b0);
    run_op("sll_poke", 4'd6, 32'd0, 32'h0000_00F3, 5'd9, 1'b1);
    run_op("srl_poke", 4'd7, 32'd0, 32'hDEAD_BEEF, 5'd13, 1'b1);

    for (int i = 0; i < 40; i++) begin
      c  = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_op($sformatf("rnd%0d_op%0d", i, c), c, ra, rb, 5'($urandom_range(0, 6)),
             1'($urandom_range(0, 1)));
    end

    // done must be a single-cycle pulse when nothing new is accepted.
    @(posedge clk); #1;
    check("done_pulse", W'(done), 0);

    // Reset arriving mid-shift with 10 steps still to go.
    alu_ctrl = 4'd6; op_b = 32'h0000_0005; shamt = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy", W'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", W'(busy), 0);
    check("abort_done", W'(done), 0);
    check("abort_result", result, 0);
    check("abort_zero", W'(zero), 1);
    check("abort_branch", W'(branch_taken), 0);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("abort_no_done", W'(dones), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
